// File: rtl/uart_tx_module.sv
// UART transmitter: start bit, 8 data bits LSB first, stop bit, registered line output.
// Define UART_TX_PARITY_EN to insert an even-parity bit between the data and stop bits.
//
// state  | meaning
// IDLE   | line high, waiting for Tx_En_Sig
// START  | driving the start bit (0)
// DATA   | driving shift_reg[0], one bit per baud period
// PARITY | driving the even-parity bit (UART_TX_PARITY_EN only)
// STOP   | driving the stop bit (1); Done pulses on exit
module uart_tx_module #(
  parameter int BAUD_DIV = 434,
  parameter int DATA_W   = 8
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic              Tx_En_Sig,
  input  logic [DATA_W-1:0] Tx_Data,
  output logic              Tx_Pin_Out,
  output logic              Tx_Busy_Sig,
  output logic              Tx_Done_Sig
);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  localparam logic [15:0] BAUD_LAST = 16'(BAUD_DIV - 1);
  localparam logic [2:0]  LAST_BIT  = 3'(DATA_W - 1);

  state_t            state, state_nxt;
  logic [15:0]       baud_cnt, baud_cnt_nxt;
  logic [2:0]        bit_idx, bit_idx_nxt;
  logic [DATA_W-1:0] shift_reg, shift_reg_nxt;
  logic              pin_nxt, busy_nxt, done_nxt;
  logic              baud_wrap;
`ifdef UART_TX_PARITY_EN
  logic              parity, parity_nxt;
`endif

  assign baud_wrap = (baud_cnt == BAUD_LAST);

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      state       <= IDLE;
      baud_cnt    <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      Tx_Pin_Out  <= 1'b1;
      Tx_Busy_Sig <= 1'b0;
      Tx_Done_Sig <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity      <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      baud_cnt    <= baud_cnt_nxt;
      bit_idx     <= bit_idx_nxt;
      shift_reg   <= shift_reg_nxt;
      Tx_Pin_Out  <= pin_nxt;
      Tx_Busy_Sig <= busy_nxt;
      Tx_Done_Sig <= done_nxt;
`ifdef UART_TX_PARITY_EN
      parity      <= parity_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt     = state;
    baud_cnt_nxt  = baud_cnt;
    bit_idx_nxt   = bit_idx;
    shift_reg_nxt = shift_reg;
    pin_nxt       = Tx_Pin_Out;
    busy_nxt      = Tx_Busy_Sig;
    done_nxt      = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_nxt    = parity;
`endif
    if (state != IDLE) baud_cnt_nxt = baud_wrap ? 16'd0 : baud_cnt + 16'd1;

    // Line value is computed one cycle ahead so Tx_Pin_Out comes straight from a flop.
    case (state)
      IDLE: begin
        pin_nxt  = 1'b1;
        busy_nxt = 1'b0;
        if (Tx_En_Sig) begin
          state_nxt     = START;
          shift_reg_nxt = Tx_Data;
          bit_idx_nxt   = '0;
          baud_cnt_nxt  = '0;
          pin_nxt       = 1'b0;
          busy_nxt      = 1'b1;
`ifdef UART_TX_PARITY_EN
          parity_nxt    = 1'b0;
`endif
        end
      end
      START: begin
        if (baud_wrap) begin
          state_nxt   = DATA;
          bit_idx_nxt = '0;
          pin_nxt     = shift_reg[0];
        end
      end
      DATA: begin
        if (baud_wrap) begin
          shift_reg_nxt = {1'b0, shift_reg[DATA_W-1:1]};
          bit_idx_nxt   = bit_idx + 3'd1;
`ifdef UART_TX_PARITY_EN
          parity_nxt    = parity ^ shift_reg[0];
`endif
          if (bit_idx == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            pin_nxt   = parity ^ shift_reg[0];
`else
            state_nxt = STOP;
            pin_nxt   = 1'b1;
`endif
          end else begin
            pin_nxt = shift_reg[1];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_wrap) begin
          state_nxt = STOP;
          pin_nxt   = 1'b1;
        end
      end
`endif
      STOP: begin
        if (baud_wrap) begin
          state_nxt = IDLE;
          busy_nxt  = 1'b0;
          done_nxt  = 1'b1;
          pin_nxt   = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        pin_nxt   = 1'b1;
        busy_nxt  = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_module.sv
// Bench for uart_tx_module: frame-level model checked every cycle plus literal frame checks.
// Two instances run side by side: BAUD_DIV=4 for directed frames, BAUD_DIV=2 for the random stream.
module tb_uart_tx_module;

`ifdef UART_TX_PARITY_EN
  localparam int FB = 11;
`else
  localparam int FB = 10;
`endif

  logic       CLK = 1'b0;
  logic       RSTn;
  logic       en4, en2;
  logic [7:0] data4, data2;
  logic       tx4, busy4, done4;
  logic       tx2, busy2, done2;

  int vectors = 0;
  int errs    = 0;
  logic chk_en = 1'b0;

  always #5 CLK = ~CLK;

  uart_tx_module #(.BAUD_DIV(4), .DATA_W(8)) u_dut4 (
    .CLK(CLK), .RSTn(RSTn), .Tx_En_Sig(en4), .Tx_Data(data4),
    .Tx_Pin_Out(tx4), .Tx_Busy_Sig(busy4), .Tx_Done_Sig(done4)
  );

  uart_tx_module #(.BAUD_DIV(2), .DATA_W(8)) u_dut2 (
    .CLK(CLK), .RSTn(RSTn), .Tx_En_Sig(en2), .Tx_Data(data2),
    .Tx_Pin_Out(tx2), .Tx_Busy_Sig(busy2), .Tx_Done_Sig(done2)
  );

  // Frame model: bit-time j of a frame carrying byte d.
  function automatic logic frame_bit(input logic [7:0] d, input int j);
    if (j == 0) return 1'b0;
    if (j >= 1 && j <= 8) return d[j-1];
`ifdef UART_TX_PARITY_EN
    if (j == 9) return ^d;
`endif
    return 1'b1;
  endfunction

  int         cyc = 0;
  logic       act  [2];
  int         kacc [2];
  logic [7:0] mdat [2];
  int         bdiv [2];

  initial begin
    bdiv[0] = 4; bdiv[1] = 2;
    act[0] = 1'b0; act[1] = 1'b0;
    kacc[0] = 0; kacc[1] = 0;
    mdat[0] = '0; mdat[1] = '0;
    forever begin
      @(posedge CLK);
      for (int d = 0; d < 2; d++) begin
        logic       en_v;
        logic [7:0] dat_v;
        en_v  = (d == 0) ? en4 : en2;
        dat_v = (d == 0) ? data4 : data2;
        if (!RSTn) act[d] = 1'b0;
        else if (en_v && (!act[d] || (cyc + 1 - kacc[d]) >= FB*bdiv[d] + 1)) begin
          act[d]  = 1'b1;
          kacc[d] = cyc + 1;
          mdat[d] = dat_v;
        end
      end
      cyc = cyc + 1;
    end
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (chk_en) begin
        for (int d = 0; d < 2; d++) begin
          logic [2:0] got, want;
          int r;
          got  = (d == 0) ? {tx4, busy4, done4} : {tx2, busy2, done2};
          r    = cyc - kacc[d];
          want = 3'b100;
          if (act[d] && r >= 0 && r < FB*bdiv[d]) want = {frame_bit(mdat[d], r / bdiv[d]), 2'b10};
          else if (act[d] && r == FB*bdiv[d]) want = 3'b101;
          vectors++;
          if (got !== want) begin
            errs++;
            $display("FAIL model_dut%0d cyc=%0d line/busy/done got %b want %b", bdiv[d], cyc, got, want);
          end
        end
      end
    end
  end

  // Independent line receiver on the BAUD_DIV=2 instance; samples the second cycle of each bit.
  logic [7:0] rx_q[$];
  logic [7:0] sent_q[$];
  int         dn2 = 0;

  initial begin
    logic       rx_on, prev;
    logic [7:0] rx_byte;
    int         rx_r, j;
    rx_on = 1'b0; prev = 1'b1; rx_byte = '0; rx_r = 0;
    forever begin
      @(negedge CLK);
      if (chk_en && RSTn) begin
        if (done2) dn2++;
        if (!rx_on) begin
          if (prev && !tx2) begin
            rx_on = 1'b1;
            rx_r  = 0;
          end
        end else begin
          rx_r++;
          j = rx_r / 2;
          if (rx_r % 2 == 1) begin
            if (j >= 1 && j <= 8) rx_byte[j-1] = tx2;
`ifdef UART_TX_PARITY_EN
            if (j == 9) begin
              vectors++;
              if (tx2 !== ^rx_byte) begin
                errs++;
                $display("FAIL rx_parity got %b want %b", tx2, ^rx_byte);
              end
            end
`endif
            if (j == FB - 1) begin
              vectors++;
              if (tx2 !== 1'b1) begin
                errs++;
                $display("FAIL rx_stop got %b want 1", tx2);
              end
              rx_q.push_back(rx_byte);
              rx_on = 1'b0;
            end
          end
        end
        prev = tx2;
      end
    end
  end

  task automatic check(input string name, input logic got, input logic want);
    vectors++;
    if (got !== want) begin
      errs++;
      $display("FAIL %s got %b want %b", name, got, want);
    end
  endtask

  task automatic send4(input logic [7:0] b);
    en4   = 1'b1;
    data4 = b;
    @(negedge CLK);
    en4   = 1'b0;
  endtask

  // Called at the first cycle of a frame on the BAUD_DIV=4 instance; runs through its Done cycle.
  task automatic grab4(input logic inject, output logic [7:0] b, output logic stp, output int dn);
    b = '0; stp = 1'b0; dn = 0;
    for (int c = 0; c <= FB*4; c++) begin
      if (c % 4 == 1 && c / 4 >= 1 && c / 4 <= 8) b[c/4-1] = tx4;
      if (c % 4 == 1 && c / 4 == FB - 1) stp = tx4;
      dn += int'(done4);
      if (inject) begin
        if (c == 4 || c == 19) begin
          en4 = 1'b1; data4 = 8'hFF;
        end else begin
          en4 = 1'b0; data4 = ~data4;
        end
      end
      @(negedge CLK);
    end
    en4 = 1'b0;
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FB-1:0] lit_a5;
    logic [7:0]    b;
    logic          stp;
    int            dn, t;

`ifdef UART_TX_PARITY_EN
    lit_a5 = 11'b10101001010;
`else
    lit_a5 = 10'b1101001010;
`endif
    RSTn = 1'b0; en4 = 1'b0; en2 = 1'b0; data4 = '0; data2 = '0;
    repeat (3) @(negedge CLK);
    chk_en = 1'b1;
    RSTn   = 1'b1;

    // Idle with no requests.
    for (int i = 0; i < 20; i++) begin
      check("idle_line", tx4, 1'b1);
      check("idle_busy", busy4, 1'b0);
      check("idle_done", done4, 1'b0);
      @(negedge CLK);
    end

    // 8'hA5 against literal line sequence and Done/Busy cycles.
    send4(8'hA5);
    for (int tp = 1; tp <= FB*4 + 1; tp++) begin
      if (tp >= 2 && (tp - 2) % 4 == 0) check("a5_line", tx4, lit_a5[(tp-2)/4]);
      if (tp == 1)      check("a5_busy_first", busy4, 1'b1);
      if (tp == FB*4) begin
        check("a5_busy_last", busy4, 1'b1);
        check("a5_done_early", done4, 1'b0);
      end
      if (tp == FB*4 + 1) begin
        check("a5_done", done4, 1'b1);
        check("a5_busy_done", busy4, 1'b0);
      end
      @(negedge CLK);
    end
    repeat (3) @(negedge CLK);

    // 8'h00 then 8'hFF requested in the Done cycle.
    send4(8'h00);
    repeat (FB*4) @(negedge CLK);
    check("b2b_done", done4, 1'b1);
    send4(8'hFF);
    check("b2b_start", tx4, 1'b0);
    grab4(1'b0, b, stp, dn);
    vectors++;
    if (b !== 8'hFF) begin errs++; $display("FAIL b2b_byte got %h want ff", b); end
    check("b2b_stop", stp, 1'b1);
    vectors++;
    if (dn != 1) begin errs++; $display("FAIL b2b_dones got %0d want 1", dn); end
    repeat (3) @(negedge CLK);

    // 8'h3C with requests and data churn mid-frame.
    send4(8'h3C);
    grab4(1'b1, b, stp, dn);
    vectors++;
    if (b !== 8'h3C) begin errs++; $display("FAIL busy_ign_byte got %h want 3c", b); end
    vectors++;
    if (dn != 1) begin errs++; $display("FAIL busy_ign_dones got %0d want 1", dn); end
    repeat (3) @(negedge CLK);

    // Reset in the middle of data bit 3 of 8'h55.
    send4(8'h55);
    repeat (17) @(negedge CLK);
    RSTn = 1'b0;
    @(negedge CLK);
    RSTn = 1'b1;
    check("rst_line", tx4, 1'b1);
    check("rst_busy", busy4, 1'b0);
    dn = 0;
    for (int i = 0; i < 50; i++) begin
      dn += int'(done4);
      @(negedge CLK);
    end
    vectors++;
    if (dn != 0) begin errs++; $display("FAIL rst_no_done got %0d want 0", dn); end
    send4(8'h81);
    grab4(1'b0, b, stp, dn);
    vectors++;
    if (b !== 8'h81) begin errs++; $display("FAIL post_rst_byte got %h want 81", b); end
    check("post_rst_stop", stp, 1'b1);

    // 256 random bytes back-to-back on the BAUD_DIV=2 instance.
    for (int i = 0; i < 256; i++) begin
      logic [7:0] rb;
      rb = 8'($urandom_range(0, 255));
      sent_q.push_back(rb);
      en2   = 1'b1;
      data2 = rb;
      @(negedge CLK);
      en2 = 1'b0;
      t = 0;
      while (!done2 && t < 60) begin
        @(negedge CLK);
        t++;
      end
      if (!done2) begin
        vectors++;
        errs++;
        $display("FAIL rand_timeout byte %0d got no done want done", i);
      end
    end
    repeat (5) @(negedge CLK);
    vectors++;
    if (rx_q.size() != 256) begin
      errs++;
      $display("FAIL rand_count got %0d want 256", rx_q.size());
    end
    for (int i = 0; i < 256 && i < rx_q.size(); i++) begin
      vectors++;
      if (rx_q[i] !== sent_q[i]) begin
        errs++;
        $display("FAIL rand_byte %0d got %h want %h", i, rx_q[i], sent_q[i]);
      end
    end
    vectors++;
    if (dn2 != 256) begin
      errs++;
      $display("FAIL rand_dones got %0d want 256", dn2);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

endmodule
